// File: rtl/pipeline_skid_stage_pkg.sv
// Shared core-stage constants: payload field layout, control width and bubble encoding.
package pipeline_skid_stage_pkg;

   localparam int unsigned PC_W   = 32;
   localparam int unsigned OPA_W  = 32;
   localparam int unsigned OPB_W  = 32;
   localparam int unsigned IMM_W  = 32;
   localparam int unsigned INSN_W = 32;

   localparam int unsigned STAGE_DATA_W = PC_W + OPA_W + OPB_W + IMM_W + INSN_W;
   localparam int unsigned STAGE_CTRL_W = 16;
   localparam int unsigned OCC_W        = 2;

   // NOP, no write-back, no mem-write
   localparam logic [STAGE_CTRL_W-1:0] BUBBLE_CTRL_DEFAULT = '0;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [OPA_W-1:0]  opa;
      logic [OPB_W-1:0]  opb;
      logic [IMM_W-1:0]  imm;
      logic [INSN_W-1:0] insn;
   } stage_payload_t;

endpackage

// File: rtl/pipeline_skid_entry.sv
// One pipeline holding register: valid, payload and control, with load and clear.
module pipeline_skid_entry
   import pipeline_skid_stage_pkg::*;
#(
   parameter int unsigned        DATA_W      = STAGE_DATA_W,
   parameter int unsigned        CTRL_W      = STAGE_CTRL_W,
   parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic [CTRL_W-1:0] load_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // Clear wins over load; a cleared entry keeps its payload but shows a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= BUBBLE_CTRL;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= BUBBLE_CTRL;
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
         ctrl  <= load_ctrl;
      end
   end

endmodule

// File: rtl/pipeline_skid_stage.sv
// Pipeline register stage with optional 2-entry skid buffer, flush-to-bubble and occupancy.
module pipeline_skid_stage
   import pipeline_skid_stage_pkg::*;
#(
   parameter int unsigned        DATA_W      = STAGE_DATA_W,
   parameter int unsigned        CTRL_W      = STAGE_CTRL_W,
   parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(BUBBLE_CTRL_DEFAULT),
   parameter int unsigned        SKID        = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_flushed,
   output logic [OCC_W-1:0]  occupancy
);

   localparam bit HAS_SKID = (SKID != 0);

   logic              main_valid;
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   logic              accept;
   logic              release_beat;
   logic              main_load;
   logic              main_clear;
   logic              main_from_skid;
   logic              skid_load;
   logic              skid_clear;
   logic              main_valid_nxt;
   logic              skid_valid_nxt;
   logic [DATA_W-1:0] main_load_data;
   logic [CTRL_W-1:0] main_load_ctrl;

   assign accept       = in_valid & in_ready & ~flush;
   assign release_beat = main_valid & out_ready & ~flush;

   // Entry steering: flush clears both, skid refills main before new input does.
   always_comb begin
      main_load      = 1'b0;
      main_clear     = flush;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = flush;
      main_valid_nxt = main_valid & ~flush;
      skid_valid_nxt = skid_valid & ~flush;
      if (!flush) begin
         if (release_beat) begin
            if (skid_valid) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               skid_load      = accept;
               skid_clear     = ~accept;
               skid_valid_nxt = accept;
            end else begin
               main_load      = accept;
               main_clear     = ~accept;
               main_valid_nxt = accept;
            end
         end else if (accept) begin
            if (main_valid) begin
               skid_load      = HAS_SKID;
               skid_valid_nxt = HAS_SKID;
            end else begin
               main_load      = 1'b1;
               main_valid_nxt = 1'b1;
            end
         end
      end
   end

   assign main_load_data = main_from_skid ? skid_data : in_data;
   assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

   pipeline_skid_entry #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_CTRL (BUBBLE_CTRL)
   ) u_main (
      .clk       (clk),
      .rst       (rst),
      .clear     (main_clear),
      .load      (main_load),
      .load_data (main_load_data),
      .load_ctrl (main_load_ctrl),
      .valid     (main_valid),
      .data      (out_data),
      .ctrl      (out_ctrl)
   );

   pipeline_skid_entry #(
      .DATA_W      (DATA_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_CTRL (BUBBLE_CTRL)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (skid_clear),
      .load      (skid_load),
      .load_data (in_data),
      .load_ctrl (in_ctrl),
      .valid     (skid_valid),
      .data      (skid_data),
      .ctrl      (skid_ctrl)
   );

   assign out_valid = main_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy   <= '0;
         out_flushed <= 1'b0;
      end else begin
         occupancy   <= OCC_W'(main_valid_nxt) + OCC_W'(skid_valid_nxt);
         out_flushed <= flush;
      end
   end

   // Skid mode breaks the out_ready -> in_ready path with a register.
   generate
      if (HAS_SKID) begin : g_skid_ready
         logic ready_q;
         always_ff @(posedge clk) begin
            if (rst) ready_q <= 1'b1;
            else     ready_q <= ~skid_valid_nxt;
         end
         assign in_ready = ready_q;
      end else begin : g_reg_ready
         assign in_ready = ~main_valid | out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Scoreboard bench for pipeline_skid_stage: one SKID=1 and one SKID=0 instance on a shared clock.
module tb_pipeline_skid_stage;
   import pipeline_skid_stage_pkg::*;

   localparam int unsigned DW = STAGE_DATA_W;
   localparam int unsigned CW = STAGE_CTRL_W;
   localparam logic [CW-1:0] BUB = BUBBLE_CTRL_DEFAULT;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          flush, in_valid, in_ready, out_valid, out_ready, out_flushed;
   logic [DW-1:0] in_data, out_data;
   logic [CW-1:0] in_ctrl, out_ctrl;
   logic [1:0]    occupancy;

   logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready, s0_out_flushed;
   logic [DW-1:0] s0_in_data, s0_out_data;
   logic [CW-1:0] s0_in_ctrl, s0_out_ctrl;
   logic [1:0]    s0_occupancy;

   pipeline_skid_stage #(.SKID(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .out_flushed(out_flushed), .occupancy(occupancy)
   );

   pipeline_skid_stage #(.SKID(0)) u_dut0 (
      .clk(clk), .rst(rst), .flush(s0_flush),
      .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
      .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
      .out_flushed(s0_out_flushed), .occupancy(s0_occupancy)
   );

   int    n_checks = 0;
   int    n_fail   = 0;
   bit    mon_en   = 1'b0;
   bit    fl_exp   = 1'b0;
   bit    acc_exp, acc0_exp;
   beat_t q[$];
   beat_t q0[$];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] dat(input logic [31:0] tag);
      stage_payload_t p;
      p      = '0;
      p.pc   = tag;
      p.imm  = tag ^ 32'h5A5A_0000;
      p.insn = ~tag;
      return p;
   endfunction

   function automatic logic [CW-1:0] ctl(input logic [31:0] tag);
      return {1'b1, tag[CW-2:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] tag);
      in_valid = 1'b1;
      in_data  = dat(tag);
      in_ctrl  = ctl(tag);
   endtask

   task automatic offer0(input logic [31:0] tag);
      s0_in_valid = 1'b1;
      s0_in_data  = dat(tag);
      s0_in_ctrl  = ctl(tag);
   endtask

   // SKID=1 scoreboard: compare held state, then apply this cycle's handshakes to the model.
   always @(negedge clk) begin
      if (mon_en) begin
         check("occupancy", DW'(occupancy), DW'(q.size()));
         check("in_ready", DW'(in_ready), DW'(q.size() < 2));
         check("out_valid", DW'(out_valid), DW'(q.size() != 0));
         check("out_flushed", DW'(out_flushed), DW'(fl_exp));
         if (q.size() != 0) begin
            check("out_data", out_data, q[0].data);
            check("out_ctrl", DW'(out_ctrl), DW'(q[0].ctrl));
         end else begin
            check("bubble_ctrl", DW'(out_ctrl), DW'(BUB));
         end
      end
      acc_exp = in_valid && (q.size() < 2);
      if (rst) begin
         q.delete();
         fl_exp = 1'b0;
      end else if (flush) begin
         q.delete();
         fl_exp = 1'b1;
      end else begin
         fl_exp = 1'b0;
         if (out_ready && q.size() != 0) void'(q.pop_front());
         if (acc_exp) q.push_back('{data: in_data, ctrl: in_ctrl});
      end
   end

   // SKID=0 scoreboard: single register, ready whenever empty or draining.
   always @(negedge clk) begin
      if (mon_en) begin
         check("s0_occupancy", DW'(s0_occupancy), DW'(q0.size()));
         check("s0_occ_max", DW'(s0_occupancy <= 2'd1), DW'(1));
         check("s0_in_ready", DW'(s0_in_ready), DW'((q0.size() == 0) || s0_out_ready));
         if (q0.size() != 0) check("s0_out_data", s0_out_data, q0[0].data);
      end
      acc0_exp = s0_in_valid && ((q0.size() == 0) || s0_out_ready);
      if (rst) begin
         q0.delete();
      end else begin
         if (s0_out_ready && q0.size() != 0) void'(q0.pop_front());
         if (acc0_exp) q0.push_back('{data: s0_in_data, ctrl: s0_in_ctrl});
      end
   end

   initial begin
      logic [31:0] tag;
      bit          acc;
      flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      s0_flush = 1'b0; s0_in_valid = 1'b0; s0_in_data = '0; s0_in_ctrl = '0; s0_out_ready = 1'b0;

      rst = 1'b1;
      repeat (3) step();
      check("rst_occ", DW'(occupancy), DW'(0));
      check("rst_in_ready", DW'(in_ready), DW'(1));
      check("rst_out_valid", DW'(out_valid), DW'(0));
      check("rst_out_data", out_data, DW'(0));
      check("rst_out_ctrl", DW'(out_ctrl), DW'(BUB));
      check("rst_flushed", DW'(out_flushed), DW'(0));
      rst = 1'b0;
      mon_en = 1'b1;

      // streaming at full rate
      out_ready = 1'b1;
      offer(32'hA1); step();
      check("stream_a1", out_data, dat(32'hA1)); check("stream_occ1", DW'(occupancy), DW'(1));
      offer(32'hA2); step();
      check("stream_a2", out_data, dat(32'hA2)); check("stream_occ2", DW'(occupancy), DW'(1));
      offer(32'hA3); step();
      check("stream_a3", out_data, dat(32'hA3)); check("stream_occ3", DW'(occupancy), DW'(1));
      in_valid = 1'b0; step();
      check("stream_drained", DW'(occupancy), DW'(0));

      // backpressure fills the skid entry
      out_ready = 1'b0;
      offer(32'hB1); step();
      check("bp_occ1", DW'(occupancy), DW'(1)); check("bp_ready1", DW'(in_ready), DW'(1));
      offer(32'hB2); step();
      check("bp_occ2", DW'(occupancy), DW'(2)); check("bp_ready0", DW'(in_ready), DW'(0));
      check("bp_head", out_data, dat(32'hB1));
      in_valid = 1'b0; out_ready = 1'b1; step();
      check("bp_b2", out_data, dat(32'hB2)); check("bp_occ_after", DW'(occupancy), DW'(1));
      step();
      check("bp_empty", DW'(out_valid), DW'(0));

      // release with full skid while input keeps offering
      out_ready = 1'b0;
      offer(32'hC1); step(); offer(32'hC2); step();
      out_ready = 1'b1; offer(32'hC3); step();
      check("skid_move", out_data, dat(32'hC2)); check("skid_move_occ", DW'(occupancy), DW'(1));
      step();
      check("skid_then_new", out_data, dat(32'hC3));
      in_valid = 1'b0; step();
      check("skid_done", DW'(occupancy), DW'(0));

      // random backpressure with continuous input
      tag = 32'h100;
      for (int i = 0; i < 48; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (i < 36) offer(tag); else in_valid = 1'b0;
         acc = in_valid && in_ready;
         step();
         if (acc) tag = tag + 32'd1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      check("rand_drained", DW'(occupancy), DW'(0));

      // flush with both entries full and a beat offered
      out_ready = 1'b0;
      offer(32'hD1); step(); offer(32'hD2); step();
      check("fl_pre_occ", DW'(occupancy), DW'(2));
      offer(32'hD3); flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_valid", DW'(out_valid), DW'(0));
      check("fl_occ", DW'(occupancy), DW'(0));
      check("fl_ctrl", DW'(out_ctrl), DW'(BUB));
      check("fl_marker", DW'(out_flushed), DW'(1));
      check("fl_data_kept", out_data, dat(32'hD1));
      step();
      check("fl_marker_drop", DW'(out_flushed), DW'(0));
      flush = 1'b1; step();
      check("fl_b2b_1", DW'(out_flushed), DW'(1));
      step();
      check("fl_b2b_2", DW'(out_flushed), DW'(1));
      flush = 1'b0; step();
      check("fl_b2b_end", DW'(out_flushed), DW'(0));
      out_ready = 1'b1; offer(32'hE1); step();
      in_valid = 1'b0;
      check("fl_after", out_data, dat(32'hE1));
      step();

      // reset mid-stream, with flush asserted alongside
      out_ready = 1'b0;
      offer(32'hF1); step(); offer(32'hF2); step();
      check("rst_mid_pre", DW'(occupancy), DW'(2));
      offer(32'hF3); rst = 1'b1; flush = 1'b1; step();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      check("rst_mid_valid", DW'(out_valid), DW'(0));
      check("rst_mid_ready", DW'(in_ready), DW'(1));
      check("rst_mid_data", out_data, DW'(0));
      check("rst_mid_occ", DW'(occupancy), DW'(0));
      check("rst_mid_flushed", DW'(out_flushed), DW'(0));
      step();

      // single-register mode: in_ready follows out_ready combinationally
      tag = 32'h200;
      for (int i = 0; i < 12; i++) begin
         s0_out_ready = ((i % 3) != 1);
         offer0(tag);
         #1;
         check("s0_ready_comb", DW'(s0_in_ready), DW'((q0.size() == 0) || s0_out_ready));
         acc = s0_in_valid && s0_in_ready;
         step();
         if (acc) tag = tag + 32'd1;
      end
      s0_in_valid = 1'b0; s0_out_ready = 1'b1;
      repeat (2) step();
      check("s0_drained", DW'(s0_occupancy), DW'(0));

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
